// File: rtl/simple_op_accum_if.sv
// Operand-pair input stream and batch-result output stream of simple_op_accum.
// The widths follow the msb/lsb override style of the simple_op hierarchy.
interface simple_op_accum_if #(
  parameter int msb1  = 3,
  parameter int msb2  = 2,
  parameter int lsb   = 0,
  parameter int cnt_w = 3,
  parameter int acc_w = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [msb1:lsb]  in_a;
  logic [msb2:lsb]  in_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [acc_w-1:0] out_sum;
  logic [cnt_w-1:0] out_n;
  logic             out_ovf;

  // Producer of operand pairs and consumer of batch results
  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_n, out_ovf
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_sum, out_n, out_ovf
  );

endinterface

// File: rtl/simple_op_accum.sv
// Batch accumulator for the simple_op datapath: sums (a + b) over `count`
// accepted pairs, or fewer when flushed, and presents one registered result
// with a sticky overflow flag on a valid/ready output.
module simple_op_accum #(
  parameter int msb1  = 3,
  parameter int msb2  = 2,
  parameter int lsb   = 0,
  parameter int count = 4,
  parameter int cnt_w = 3,
  parameter int acc_w = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  simple_op_accum_if.slave bus
);

  localparam int A_W = msb1 - lsb + 1;
  localparam int B_W = msb2 - lsb + 1;
  localparam logic [cnt_w-1:0] LAST_IDX = cnt_w'(count - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [acc_w-1:0] acc_q, acc_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [acc_w-1:0] sum_q, sum_d;
  logic [cnt_w-1:0] n_q, n_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             emit;
  logic [acc_w:0]   aExt;
  logic [acc_w:0]   bExt;
  logic [acc_w:0]   sampleFull;
  logic [acc_w:0]   accFull;
  logic [acc_w-1:0] sample;
  logic [acc_w-1:0] accNext;
  logic             addCarry;

  // Sample datapath: operands are masked when idle so that undriven
  // inputs never reach the accumulator; carries from both adds feed the
  // sticky overflow flag.
  always_comb begin
    aExt = '0;
    bExt = '0;
    if (bus.in_valid) begin
      aExt = {{(acc_w + 1 - A_W){1'b0}}, bus.in_a};
      bExt = {{(acc_w + 1 - B_W){1'b0}}, bus.in_b};
    end
    sampleFull = aExt + bExt;
    sample     = sampleFull[acc_w-1:0];
    accFull    = {1'b0, acc_q} + {1'b0, sample};
    accNext    = accFull[acc_w-1:0];
    addCarry   = sampleFull[acc_w] | accFull[acc_w];
  end

  // Next-state logic: accumulate in ACCUM, close the batch on the last
  // sample or a useful flush, then park the result in HOLD until taken.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    n_d      = n_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    emit     = 1'b0;

    case (state_q)
      ACCUM: begin
        accept = bus.in_valid;
        emit   = (accept && (cnt_q == LAST_IDX)) ||
                 (bus.flush && ((cnt_q != '0) || accept));
        if (accept) begin
          acc_d    = accNext;
          cnt_d    = cnt_q + cnt_w'(1);
          sticky_d = sticky_q | addCarry;
        end
        if (emit) begin
          sum_d    = accept ? accNext : acc_q;
          n_d      = cnt_q + {{(cnt_w - 1){1'b0}}, accept};
          ovf_d    = sticky_q | (accept & addCarry);
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset; reset
  // drops any partial batch and any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      n_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      n_q      <= n_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_n     = n_q;
  assign bus.out_ovf   = ovf_q;

  // A pending result stays put, unchanged, until the consumer takes it.
  property resultHeld;
    @(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_sum) && $stable(bus.out_n) && $stable(bus.out_ovf));
  endproperty
  assert property (resultHeld);

  // Input and output sides are never open at the same time.
  property exclusiveReady;
    @(posedge clk) disable iff (!rst_n)
      !(bus.in_ready && bus.out_valid);
  endproperty
  assert property (exclusiveReady);

endmodule

// File: tb/tb_simple_op_accum.sv
// Directed table-driven bench for simple_op_accum: three instances with
// different width/count overrides share one clock and reset.
module tb_simple_op_accum;

  typedef struct {
    int         sel;
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       fl;
    logic       ordy;
    logic       eValid;
    logic       eRdy;
    logic [8:0] eSum;
    logic [2:0] eN;
    logic       eOvf;
  } vec_t;

  logic       clk;
  logic       rst_n;
  int         sel;
  logic       drvValid;
  logic [7:0] drvA;
  logic [7:0] drvB;
  logic       drvFlush;
  logic       drvReady;

  logic       monValid;
  logic       monRdy;
  logic [8:0] monSum;
  logic [2:0] monN;
  logic       monOvf;

  int testsRun;
  int testsFailed;
  vec_t vecs[$];

  simple_op_accum_if #(.msb1(3), .msb2(2), .lsb(0), .cnt_w(3), .acc_w(8)) if0 ();
  simple_op_accum_if #(.msb1(3), .msb2(2), .lsb(0), .cnt_w(3), .acc_w(5)) if1 ();
  simple_op_accum_if #(.msb1(7), .msb2(7), .lsb(0), .cnt_w(3), .acc_w(9)) if2 ();

  simple_op_accum #(.msb1(3), .msb2(2), .lsb(0), .count(4), .cnt_w(3), .acc_w(8))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  simple_op_accum #(.msb1(3), .msb2(2), .lsb(0), .count(4), .cnt_w(3), .acc_w(5))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  simple_op_accum #(.msb1(7), .msb2(7), .lsb(0), .count(1), .cnt_w(3), .acc_w(9))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the selected instance sees activity; the others idle.
  assign if0.in_valid  = drvValid && (sel == 0);
  assign if0.flush     = drvFlush && (sel == 0);
  assign if0.out_ready = drvReady && (sel == 0);
  assign if0.in_a      = drvA[3:0];
  assign if0.in_b      = drvB[2:0];
  assign if1.in_valid  = drvValid && (sel == 1);
  assign if1.flush     = drvFlush && (sel == 1);
  assign if1.out_ready = drvReady && (sel == 1);
  assign if1.in_a      = drvA[3:0];
  assign if1.in_b      = drvB[2:0];
  assign if2.in_valid  = drvValid && (sel == 2);
  assign if2.flush     = drvFlush && (sel == 2);
  assign if2.out_ready = drvReady && (sel == 2);
  assign if2.in_a      = drvA;
  assign if2.in_b      = drvB;

  // Monitor mux for the selected instance
  always_comb begin
    monValid = if0.out_valid;
    monRdy   = if0.in_ready;
    monSum   = {1'b0, if0.out_sum};
    monN     = if0.out_n;
    monOvf   = if0.out_ovf;
    if (sel == 1) begin
      monValid = if1.out_valid;
      monRdy   = if1.in_ready;
      monSum   = {4'b0, if1.out_sum};
      monN     = if1.out_n;
      monOvf   = if1.out_ovf;
    end else if (sel == 2) begin
      monValid = if2.out_valid;
      monRdy   = if2.in_ready;
      monSum   = if2.out_sum;
      monN     = if2.out_n;
      monOvf   = if2.out_ovf;
    end
  end

  function automatic vec_t mk(int s, logic v, int a, int b, logic fl, logic ordy,
                              logic ev, logic er, int sum, int n, logic ovf);
    vec_t r;
    r.sel    = s;
    r.v      = v;
    r.a      = 8'(a);
    r.b      = 8'(b);
    r.fl     = fl;
    r.ordy   = ordy;
    r.eValid = ev;
    r.eRdy   = er;
    r.eSum   = 9'(sum);
    r.eN     = 3'(n);
    r.eOvf   = ovf;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b, input logic fl, input logic ordy);
    drvValid = v;
    drvA     = 8'(a);
    drvB     = 8'(b);
    drvFlush = fl;
    drvReady = ordy;
  endtask

  task automatic applyStimulus(input vec_t t);
    sel = t.sel;
    drive(t.v, int'(t.a), int'(t.b), t.fl, t.ordy);
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Data fields are only meaningful while a result is pending.
  task automatic checkAll(input string tag, input logic ev, input logic er,
                          input int sum, input int n, input logic ovf, input logic chkData);
    checkOutput({tag, " out_valid"}, 32'(monValid), 32'(ev));
    checkOutput({tag, " in_ready"}, 32'(monRdy), 32'(er));
    if (chkData) begin
      checkOutput({tag, " out_sum"}, 32'(monSum), 32'(sum));
      checkOutput({tag, " out_n"}, 32'(monN), 32'(n));
      checkOutput({tag, " out_ovf"}, 32'(monOvf), 32'(ovf));
    end
  endtask

  task automatic resetCheck(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checkAll($sformatf("%s dut%0d", tag, s), 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    end
    sel = 0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    sel         = 0;
    rst_n       = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);

    // Directed vectors: {sel, v, a, b, flush, out_ready, expected valid/ready/sum/n/ovf}
    // dut0: four back-to-back pairs, result one cycle after the last accept
    vecs.push_back(mk(0, 1, 15, 7, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 0, 1, 1, 0, 29, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // dut0: backpressure for five cycles with a pair waiting at the input
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 3, 0, 0, 1, 0, 20, 4, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 20, 4, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // dut0: partial batches
    vecs.push_back(mk(0, 1, 3, 2, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 10, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 1, 0, 1, 0, 15, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 15, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 1, 1, 0, 12, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // dut1 (acc_w=5): wrapping batch, then clean batch with sticky cleared
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 15, 7, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 15, 7, 0, 1, 1, 0, 24, 4, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 1, 0, 8, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 15, 7, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 15, 7, 1, 1, 1, 0, 12, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // dut2 (count=1, 8-bit operands, acc_w=9): every accept emits
    vecs.push_back(mk(2, 1, 255, 255, 0, 1, 1, 0, 510, 1, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 1, 200, 100, 0, 1, 1, 0, 300, 1, 0));
    vecs.push_back(mk(2, 1, 7, 9, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 1, 7, 9, 0, 1, 1, 0, 16, 1, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

    // Reset values on all three instances
    tick();
    tick();
    resetCheck("reset");
    rst_n = 1'b1;
    checkAll("post-reset dut0", 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);

    // Flush alone right after reset produces nothing
    sel = 0;
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    tick();
    checkAll("flush-empty", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    tick();
    checkAll("flush-empty next", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eRdy,
               int'(vecs[i].eSum), int'(vecs[i].eN), vecs[i].eOvf, vecs[i].eValid);
    end

    // Reset in the middle of a batch discards the partial sum
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5, 5, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    checkAll("rst mid-batch", 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Reset while a result is pending drops it
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, 3, 1'b0, 1'b0);
      tick();
    end
    checkAll("pre-rst hold", 1'b1, 1'b0, 24, 4, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    checkAll("rst mid-hold", 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // A clean batch after both resets starts from zero
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1, 1, 1'b0, 1'b1);
      tick();
    end
    checkAll("post-rst batch", 1'b1, 1'b0, 8, 4, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    tick();
    checkAll("post-rst release", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
